wb_port_arbiter: RTL and testbench

//  Owns the single register-file write port behind the write-back stage.

---
 rtl/wb_port_arbiter_pkg.sv | 21 ++
 rtl/wb_port_arbiter_if.sv | 46 ++++
 rtl/wb_load_fifo.sv | 56 +++++
 rtl/wb_port_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and defaults for the write-back port arbiter: grant-history
// state encoding, grant selector, and default geometry.
package wb_port_arbiter_pkg;

  localparam int DATA_W_DEFAULT   = 64;
  localparam int REG_W_DEFAULT    = 5;
  localparam int LQ_DEPTH_DEFAULT = 4;
  localparam int ZERO_REG_DEFAULT = 31;

  typedef enum logic {
    ALU_LAST = 1'b0,
    LD_LAST  = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LD   = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of ALU, load-return, register-file and queue-status signals.
// WB_SCOREBOARD_EN adds the load-issue inputs and the busy_vec output.
interface wb_port_arbiter_if #(
  parameter int DATA_W   = 64,
  parameter int REG_W    = 5,
  parameter int LQ_DEPTH = 4
);
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_W-1:0]  alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [REG_W-1:0]  ld_reg;
  logic [DATA_W-1:0] ld_data;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  lq_count;
`ifdef WB_SCOREBOARD_EN
  logic                    ld_issue_valid;
  logic [REG_W-1:0]        ld_issue_reg;
  logic [(2**REG_W)-1:0]   busy_vec;
`endif

  modport master (
    output alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
`ifdef WB_SCOREBOARD_EN
    output ld_issue_valid, ld_issue_reg,
    input  busy_vec,
`endif
    input  alu_ready, ld_ready, rf_we, rf_waddr, rf_wdata, lq_count
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
`ifdef WB_SCOREBOARD_EN
    input  ld_issue_valid, ld_issue_reg,
    output busy_vec,
`endif
    output alu_ready, ld_ready, rf_we, rf_waddr, rf_wdata, lq_count
  );

endinterface

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO holding returned loads {reg, data} until the write port
// is granted to the load side. Depth must be a power of two.
module wb_load_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; the count and pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin owner of the single register-file write port (ALU vs queued loads).
// Optional WB_SCOREBOARD_EN adds per-register pending-load tracking (busy_vec).
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int REG_W    = REG_W_DEFAULT,
  parameter int LQ_DEPTH = LQ_DEPTH_DEFAULT,
  parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
  input logic              i_clk,
  input logic              i_reset,
  wb_port_arbiter_if.slave i_wb
);

  localparam int ENTRY_W = REG_W + DATA_W;
  localparam int CNT_W   = $clog2(LQ_DEPTH) + 1;
  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  logic               w_lq_push;
  logic               w_lq_pop;
  logic               w_lq_full;
  logic               w_lq_empty;
  logic [CNT_W-1:0]   w_lq_count;
  logic [ENTRY_W-1:0] w_lq_din;
  logic [ENTRY_W-1:0] w_lq_dout;

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  grant_e             w_grant;
  logic               w_alu_ready;
  logic [REG_W-1:0]   w_win_reg;
  logic [DATA_W-1:0]  w_win_data;

  logic               r_rf_we;
  logic [REG_W-1:0]   r_rf_waddr;
  logic [DATA_W-1:0]  r_rf_wdata;

  assign w_lq_push = i_wb.ld_valid && !w_lq_full;
  assign w_lq_pop  = (w_grant == GNT_LD);
  assign w_lq_din  = {i_wb.ld_reg, i_wb.ld_data};

  wb_load_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LQ_DEPTH)
  ) u_load_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_lq_push),
    .i_pop   (w_lq_pop),
    .i_din   (w_lq_din),
    .o_dout  (w_lq_dout),
    .o_full  (w_lq_full),
    .o_empty (w_lq_empty),
    .o_count (w_lq_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= LD_LAST;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first so no latch can form.
  always_comb begin
    w_alu_ready = !(!w_lq_empty && (w_lq_full || r_state == ALU_LAST));
    w_grant     = GNT_NONE;
    w_state_nxt = r_state;
    w_win_reg   = i_wb.alu_reg;
    w_win_data  = i_wb.alu_data;
    if (i_wb.alu_valid && w_alu_ready) begin
      w_grant     = GNT_ALU;
      w_state_nxt = ALU_LAST;
    end else if (!w_lq_empty) begin
      w_grant                 = GNT_LD;
      w_state_nxt             = LD_LAST;
      {w_win_reg, w_win_data} = w_lq_dout;
    end
  end

  // A zero-register winner still consumes its grant; only the enable is dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= (w_grant != GNT_NONE) && (w_win_reg != ZERO_IDX);
      if (w_grant != GNT_NONE) begin
        r_rf_waddr <= w_win_reg;
        r_rf_wdata <= w_win_data;
      end
    end
  end

  assign i_wb.alu_ready = w_alu_ready;
  assign i_wb.ld_ready  = !w_lq_full;
  assign i_wb.rf_we     = r_rf_we;
  assign i_wb.rf_waddr  = r_rf_waddr;
  assign i_wb.rf_wdata  = r_rf_wdata;
  assign i_wb.lq_count  = w_lq_count;

`ifdef WB_SCOREBOARD_EN
  logic                  r_rf_from_ld;
  logic [(2**REG_W)-1:0] r_busy_vec;
  logic [(2**REG_W)-1:0] w_busy_set;
  logic [(2**REG_W)-1:0] w_busy_clr;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_rf_from_ld <= 1'b0;
    else         r_rf_from_ld <= (w_grant == GNT_LD);
  end

  // Clear lands in the commit cycle; a same-cycle reissue set overrides it.
  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (i_wb.ld_issue_valid && (i_wb.ld_issue_reg != ZERO_IDX))
      w_busy_set[i_wb.ld_issue_reg] = 1'b1;
    if (r_rf_we && r_rf_from_ld)
      w_busy_clr[r_rf_waddr] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_busy_vec <= '0;
    else         r_busy_vec <= (r_busy_vec & ~w_busy_clr) | w_busy_set;
  end

  assign i_wb.busy_vec = r_busy_vec;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// each register-file write; an independent monitor pops and compares them.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int DATA_W   = 64;
  localparam int REG_W    = 5;
  localparam int LQ_DEPTH = 4;
  localparam int ZERO_REG = ZERO_REG_DEFAULT;

  typedef struct packed {
    logic [REG_W-1:0]  r;
    logic [DATA_W-1:0] d;
  } ld_t;

  typedef struct packed {
    logic [REG_W-1:0]  r;
    logic [DATA_W-1:0] d;
    logic [31:0]       cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cyc_cnt = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

  wb_port_arbiter_if #(.DATA_W(DATA_W), .REG_W(REG_W), .LQ_DEPTH(LQ_DEPTH)) bus ();

  wb_port_arbiter #(
    .DATA_W   (DATA_W),
    .REG_W    (REG_W),
    .LQ_DEPTH (LQ_DEPTH),
    .ZERO_REG (ZERO_REG)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_wb    (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  ld_t  m_lq[$];
  wr_t  exp_q[$];
  bit   m_last_alu = 1'b0;
  bit   alu_acc;
  bit   ld_acc;
  logic seen_alu_ready;
  logic seen_ld_ready;
`ifdef WB_SCOREBOARD_EN
  logic             sb_iv = 1'b0;
  logic [REG_W-1:0] sb_ir = '0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc_cnt);
    end
  endtask

  // Reference model: loads wait in a queue in arrival order; when both sides
  // want the port, a full queue wins, otherwise the side that waited last time.
  task automatic model_step(input bit av, input logic [REG_W-1:0] ar, input logic [DATA_W-1:0] ad,
                            input bit lv, input logic [REG_W-1:0] lr, input logic [DATA_W-1:0] ld);
    int  sz;
    bit  full;
    bit  alu_would_win;
    ld_t e;
    sz            = m_lq.size();
    full          = (sz == LQ_DEPTH);
    alu_would_win = (sz == 0) || (!full && !m_last_alu);
    check("alu_ready", 64'(bus.alu_ready), 64'(alu_would_win));
    check("ld_ready", 64'(bus.ld_ready), 64'(!full));
    check("lq_count", 64'(bus.lq_count), 64'(sz));
    seen_alu_ready = bus.alu_ready;
    seen_ld_ready  = bus.ld_ready;
    alu_acc = av && alu_would_win;
    ld_acc  = lv && !full;
    if (alu_acc) begin
      if (ar != REG_W'(ZERO_REG)) exp_q.push_back('{r: ar, d: ad, cyc: cyc_cnt + 32'd1});
      m_last_alu = 1'b1;
    end else if (sz != 0) begin
      e = m_lq.pop_front();
      if (e.r != REG_W'(ZERO_REG)) exp_q.push_back('{r: e.r, d: e.d, cyc: cyc_cnt + 32'd1});
      m_last_alu = 1'b0;
    end
    if (ld_acc) m_lq.push_back('{r: lr, d: ld});
  endtask

  task automatic cycle(input bit av, input logic [REG_W-1:0] ar, input logic [DATA_W-1:0] ad,
                       input bit lv, input logic [REG_W-1:0] lr, input logic [DATA_W-1:0] ld);
    bus.alu_valid = av;
    bus.alu_reg   = ar;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_reg    = lr;
    bus.ld_data   = ld;
`ifdef WB_SCOREBOARD_EN
    bus.ld_issue_valid = sb_iv;
    bus.ld_issue_reg   = sb_ir;
`endif
    @(negedge clk);
    model_step(av, ar, ad, lv, lr, ld);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    reset         = 1'b1;
    bus.alu_valid = 1'b0;
    bus.alu_reg   = '0;
    bus.alu_data  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_reg    = '0;
    bus.ld_data   = '0;
`ifdef WB_SCOREBOARD_EN
    sb_iv              = 1'b0;
    bus.ld_issue_valid = 1'b0;
    bus.ld_issue_reg   = '0;
`endif
    repeat (n) @(posedge clk);
    #1;
    m_lq.delete();
    exp_q.delete();
    m_last_alu = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic post_reset_checks();
    check("rst_rf_we", 64'(bus.rf_we), 64'd0);
    check("rst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    check("rst_rf_wdata", bus.rf_wdata, 64'd0);
    check("rst_lq_count", 64'(bus.lq_count), 64'd0);
    check("rst_ld_ready", 64'(bus.ld_ready), 64'd1);
    check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
  endtask

  function automatic logic [REG_W-1:0] rand_reg();
    return ($urandom_range(7) == 0) ? REG_W'(ZERO_REG) : REG_W'($urandom_range(30));
  endfunction

  // Producers hold an offered item until it is accepted.
  task automatic run_stream(input int n, input int alu_pct, input int ld_pct);
    bit                av = 1'b0;
    bit                lv = 1'b0;
    logic [REG_W-1:0]  ar = '0;
    logic [REG_W-1:0]  lr = '0;
    logic [DATA_W-1:0] ad = '0;
    logic [DATA_W-1:0] ld = '0;
    for (int i = 0; i < n; i++) begin
      if (!av) begin
        av = ($urandom_range(99) < alu_pct);
        ar = rand_reg();
        ad = {$urandom, $urandom};
      end
      if (!lv) begin
        lv = ($urandom_range(99) < ld_pct);
        lr = rand_reg();
        ld = {$urandom, $urandom};
      end
      cycle(av, ar, ad, lv, lr, ld);
      if (alu_acc) av = 1'b0;
      if (ld_acc)  lv = 1'b0;
    end
  endtask

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rf_unexpected: write r%0d=0x%0h with nothing expected at cycle %0d",
                   bus.rf_waddr, bus.rf_wdata, cyc_cnt);
        end else begin
          e = exp_q.pop_front();
          check("rf_waddr", 64'(bus.rf_waddr), 64'(e.r));
          check("rf_wdata", bus.rf_wdata, e.d);
          check("rf_commit_cycle", 64'(cyc_cnt), 64'(e.cyc));
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc == cyc_cnt) begin
        e = exp_q.pop_front();
        check("rf_we_missing", 64'(bus.rf_we), 64'd1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic              ready_seq [4];
    logic [3:0]        ready_exp;
    logic [REG_W-1:0]  ar;
    logic [REG_W-1:0]  lr;
    logic [DATA_W-1:0] ad;
    logic [DATA_W-1:0] ld;
    bit                saw_full;
    int                budget;

    do_reset(3);
    post_reset_checks();

    // ALU-only back-to-back writes
    cycle(1'b1, 5'd3, 64'h11, 1'b0, '0, '0);
    cycle(1'b1, 5'd4, 64'h22, 1'b0, '0, '0);
    idle(3);

    // Lone load: two-cycle latency through the queue
    cycle(1'b0, '0, '0, 1'b1, 5'd5, 64'hAA);
    idle(3);

    // Alternation from LD_LAST with both sides busy
    cycle(1'b0, '0, '0, 1'b1, 5'd8, 64'hB0);
    cycle(1'b0, '0, '0, 1'b1, 5'd9, 64'hB1);
    cycle(1'b1, 5'd10, 64'hC0, 1'b1, 5'd11, 64'hB2);
    ready_seq[0] = seen_alu_ready;
    cycle(1'b1, 5'd12, 64'hC1, 1'b1, 5'd13, 64'hB3);
    ready_seq[1] = seen_alu_ready;
    cycle(1'b1, 5'd12, 64'hC1, 1'b0, '0, '0);
    ready_seq[2] = seen_alu_ready;
    cycle(1'b1, 5'd14, 64'hC2, 1'b0, '0, '0);
    ready_seq[3] = seen_alu_ready;
    cycle(1'b1, 5'd14, 64'hC2, 1'b0, '0, '0);
    ready_exp = 4'b0101;
    for (int i = 0; i < 4; i++) check($sformatf("alt_alu_ready_%0d", i), 64'(ready_seq[i]), 64'(ready_exp[i]));
    idle(6);

    // Fill the queue with ALU continuously requesting
    ar = 5'd20; ad = 64'hE0; lr = 5'd16; ld = 64'hD0; saw_full = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, ar, ad, 1'b1, lr, ld);
      if (seen_ld_ready !== 1'b1) saw_full = 1'b1;
      if (alu_acc) begin ar = ar + 5'd1; ad = ad + 64'd1; end
      if (ld_acc)  begin lr = (lr == 5'd19) ? 5'd16 : lr + 5'd1; ld = ld + 64'd1; end
    end
    check("fill_ld_ready_low_seen", 64'(saw_full), 64'd1);
    idle(8);

    // Zero-register write is dropped, next write commits
    cycle(1'b1, 5'd31, 64'hEE, 1'b0, '0, '0);
    check("zero_reg_alu_ready", 64'(seen_alu_ready), 64'd1);
    cycle(1'b1, 5'd1, 64'h5A5A, 1'b0, '0, '0);
    idle(3);

    run_stream(500, 60, 50);
    run_stream(200, 90, 90);

    // Reset in the middle of traffic
    run_stream(12, 80, 95);
    do_reset(2);
    post_reset_checks();
    run_stream(150, 60, 50);
    idle(8);

`ifdef WB_SCOREBOARD_EN
    sb_iv = 1'b1; sb_ir = 5'd7;
    idle(1);
    sb_iv = 1'b0;
    check("sb_busy7_set", 64'(bus.busy_vec[7]), 64'd1);
    cycle(1'b0, '0, '0, 1'b1, 5'd7, 64'h77);
    idle(1);
    sb_iv = 1'b1; sb_ir = 5'd7;
    idle(1);
    sb_iv = 1'b0;
    check("sb_busy7_reissue_holds", 64'(bus.busy_vec[7]), 64'd1);
    cycle(1'b0, '0, '0, 1'b1, 5'd7, 64'h78);
    idle(3);
    check("sb_busy7_cleared", 64'(bus.busy_vec[7]), 64'd0);
    sb_iv = 1'b1; sb_ir = 5'd31;
    idle(1);
    sb_iv = 1'b0;
    check("sb_zero_reg_never_busy", 64'(bus.busy_vec[31]), 64'd0);
`endif

    budget = 40;
    while ((exp_q.size() != 0 || m_lq.size() != 0) && budget > 0) begin
      idle(1);
      budget--;
    end
    idle(2);
    check("drain_expected_empty", 64'(exp_q.size()), 64'd0);
    check("drain_lq_count", 64'(bus.lq_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
